// File: rtl/regfile_snapshot_streamer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_snapshot_streamer
// Purpose  : Freezes a coherent snapshot of the tapped integer registers on a
//            trigger and streams it out one register per beat over a
//            valid/ready interface.
// Options  : REGSNAP_DELTA_EN - when defined, only entries that differ from
//            the previously streamed snapshot are sent.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_snapshot_streamer #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREGS*XLEN-1:0] regs_in,
  input  logic                  trigger,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_last,
  output logic [15:0]           snap_count,
  output logic [7:0]            drop_count
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      snap_count_q, snap_count_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic [XLEN-1:0]  regs_w [NREGS];
  logic [XLEN-1:0]  snap_q [NREGS];
  logic [XLEN-1:0]  snap_d [NREGS];
  logic             capture;
  logic             handshake;
  logic             is_last;
  logic [IDX_W-1:0] cur_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_unpack
      assign regs_w[gi] = regs_in[gi*XLEN +: XLEN];
    end
  endgenerate

  assign busy      = (state_q == ST_STREAM);
  assign handshake = busy & out_ready;

`ifdef REGSNAP_DELTA_EN
  localparam logic [NREGS-1:0] ONE_MASK = NREGS'(1);

  logic [XLEN-1:0]  shadow_q [NREGS];
  logic [XLEN-1:0]  shadow_d [NREGS];
  logic             shadow_vld_q, shadow_vld_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] change_mask;

  // Per-entry change mask; capture happens on the same edge, so live regs_in
  // equals the snapshot being taken. No valid shadow means everything changed.
  always_comb begin
    change_mask = '0;
    for (int i = 0; i < NREGS; i++) begin
      change_mask[i] = !shadow_vld_q || (regs_w[i] != shadow_q[i]);
    end
  end

  // Priority encoder: lowest pending entry is the current beat.
  always_comb begin
    cur_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (pend_q[i]) cur_idx = IDX_W'(i);
    end
  end

  // Last beat when at most one pending bit remains.
  assign is_last = ((pend_q & (pend_q - ONE_MASK)) == '0);

  // Pending-mask and shadow next-state.
  always_comb begin
    pend_d       = pend_q;
    shadow_vld_d = shadow_vld_q;
    shadow_d     = shadow_q;
    if (capture) begin
      // With no changes a single beat of entry 0 still marks the snapshot.
      pend_d = (change_mask == '0) ? ONE_MASK : change_mask;
    end else if (handshake) begin
      if (is_last) begin
        shadow_d     = snap_q;
        shadow_vld_d = 1'b1;
      end else begin
        pend_d = pend_q & (pend_q - ONE_MASK);
      end
    end
  end

  // Pending mask and shadow-valid registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q       <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end

  // Shadow contents carry no reset; shadow_vld qualifies them.
  always_ff @(posedge clock) begin
    shadow_q <= shadow_d;
  end
`else
  logic [IDX_W-1:0] idx_q, idx_d;

  assign cur_idx = idx_q;
  assign is_last = (idx_q == IDX_W'(NREGS - 1));

  // Beat index walks 0..NREGS-1 in order.
  always_comb begin
    idx_d = idx_q;
    if (capture) begin
      idx_d = '0;
    end else if (handshake && !is_last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Beat index register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) idx_q <= '0;
    else          idx_q <= idx_d;
  end
`endif

  // FSM next-state, capture strobe and counters.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    snap_count_d = snap_count_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          capture      = 1'b1;
          snap_count_d = snap_count_q + 16'd1;
          state_d      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Triggers while busy are dropped, including on the final beat.
        if (trigger && (drop_count_q != 8'hFF)) begin
          drop_count_d = drop_count_q + 8'd1;
        end
        if (handshake && is_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Snapshot array loads only on an accepted trigger.
  always_comb begin
    snap_d = snap_q;
    if (capture) snap_d = regs_w;
  end

  // Snapshot storage; no reset needed since it is only read while streaming.
  always_ff @(posedge clock) begin
    snap_q <= snap_d;
  end

  // FSM state and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      snap_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      snap_count_q <= snap_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Beat outputs are forced to zero outside a stream.
  assign out_valid  = busy;
  assign out_idx    = busy ? cur_idx : '0;
  assign out_data   = busy ? snap_q[cur_idx] : '0;
  assign out_last   = busy & is_last;
  assign snap_count = snap_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_snapshot_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_snapshot_streamer
// Purpose  : Directed self-checking bench for regfile_snapshot_streamer.
//            Define REGSNAP_DELTA_EN to also exercise the delta-stream option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_snapshot_streamer;
  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam int IDX_W = 5;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREGS*XLEN-1:0] regs_in = '0;
  logic                  trigger = 1'b0;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [IDX_W-1:0]      out_idx;
  logic [XLEN-1:0]       out_data;
  logic                  out_last;
  logic [15:0]           snap_count;
  logic [7:0]            drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_snapshot_streamer #(.NREGS(NREGS), .XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .regs_in   (regs_in),
    .trigger   (trigger),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .snap_count(snap_count),
    .drop_count(drop_count)
  );

  task automatic set_regs(input logic [31:0] base);
    for (int i = 0; i < NREGS; i++) regs_in[i*XLEN +: XLEN] = base + 32'(i);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; trigger = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Leaves the bench at the negedge where beat 0 is first visible.
  task automatic pulse_trigger();
    @(negedge clock); trigger = 1'b1;
    @(negedge clock); trigger = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", out_last); end
    checks++; if (snap_count !== 16'd0) begin errors++; $display("FAIL reset_snap got %0d want 0", snap_count); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    reset_n = 1'b1;
  endtask

  // T1: full stream with sink always ready.
  task automatic test_full_stream();
    do_reset();
    set_regs(32'h1000); out_ready = 1'b1;
    pulse_trigger();
    for (int k = 0; k < NREGS; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid beat %0d got %0b want 1", k, out_valid); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL t1_idx got %0d want %0d", out_idx, k); end
      checks++; if (out_data !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL t1_data idx %0d got %h want %h", k, out_data, 32'h1000 + 32'(k)); end
      checks++; if (out_last !== (k == NREGS - 1)) begin errors++; $display("FAIL t1_last idx %0d got %0b want %0b", k, out_last, (k == NREGS - 1)); end
      @(negedge clock);
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_end valid/busy got %0b/%0b want 0/0", out_valid, busy); end
    checks++; if (snap_count !== 16'd1) begin errors++; $display("FAIL t1_snap got %0d want 1", snap_count); end
  endtask

  // T2: sink stalls every other cycle, live registers change mid-stream.
  task automatic test_stall();
    int k;
    int cyc;
    do_reset();
    set_regs(32'h1000); out_ready = 1'b0;
    pulse_trigger();
    k = 0; cyc = 0;
    while (k < NREGS && cyc < 200) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid cyc %0d got %0b want 1", cyc, out_valid); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL t2_idx cyc %0d got %0d want %0d", cyc, out_idx, k); end
      checks++; if (out_data !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL t2_data cyc %0d got %h want %h", cyc, out_data, 32'h1000 + 32'(k)); end
      checks++; if (out_last !== (k == NREGS - 1)) begin errors++; $display("FAIL t2_last cyc %0d got %0b want %0b", cyc, out_last, (k == NREGS - 1)); end
      if (cyc == 6) set_regs(32'hABCD_0000);
      out_ready = ((cyc % 2) == 1);
      if (out_ready) k++;
      cyc++;
      @(negedge clock);
    end
    checks++; if (k != NREGS) begin errors++; $display("FAIL t2_timeout beats got %0d want %0d", k, NREGS); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_end valid got %0b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  // T3: trigger held for 40 cycles; second snapshot right after the last beat.
  task automatic test_held_trigger();
    do_reset();
    set_regs(32'h3000); out_ready = 1'b1;
    @(negedge clock); trigger = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 32) begin
        checks++; if (out_last !== 1'b1 || out_idx !== 5'd31) begin errors++; $display("FAIL t3_last got last=%0b idx=%0d want 1/31", out_last, out_idx); end
      end
      if (n == 33) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_gap busy got %0b want 0", busy); end
        set_regs(32'h4000);
      end
      if (n == 34) begin
        checks++; if (busy !== 1'b1 || out_idx !== 5'd0) begin errors++; $display("FAIL t3_second got busy=%0b idx=%0d want 1/0", busy, out_idx); end
      end
    end
    trigger = 1'b0;
    checks++; if (drop_count !== 8'd38) begin errors++; $display("FAIL t3_drop got %0d want 38", drop_count); end
    checks++; if (snap_count !== 16'd2) begin errors++; $display("FAIL t3_snap got %0d want 2", snap_count); end
    for (int c = 0; c < 100 && busy; c++) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_drain busy got %0b want 0", busy); end
  endtask

  // T4: asynchronous reset mid-stream, then a clean full stream.
  task automatic test_mid_reset();
    int beats;
    int bad;
    do_reset();
    set_regs(32'h5000); out_ready = 1'b1;
    pulse_trigger();
    trigger = 1'b1;
    @(negedge clock); trigger = 1'b0;
    repeat (9) @(negedge clock);
    checks++; if (out_idx !== 5'd10) begin errors++; $display("FAIL t4_pre_idx got %0d want 10", out_idx); end
    checks++; if (snap_count !== 16'd1 || drop_count !== 8'd1) begin errors++; $display("FAIL t4_pre_cnt got %0d/%0d want 1/1", snap_count, drop_count); end
    reset_n = 1'b0;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t4_abort valid/busy got %0b/%0b want 0/0", out_valid, busy); end
    checks++; if (snap_count !== 16'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL t4_cnt got %0d/%0d want 0/0", snap_count, drop_count); end
    @(negedge clock); reset_n = 1'b1;
    pulse_trigger();
    beats = 0; bad = 0;
    for (int c = 0; c < 100 && out_valid; c++) begin
      if (out_idx !== 5'(beats) || out_data !== 32'h5000 + 32'(beats) || out_last !== (beats == NREGS - 1)) bad++;
      beats++;
      @(negedge clock);
    end
    checks++; if (beats != NREGS || bad != 0) begin errors++; $display("FAIL t4_restream beats %0d bad %0d want %0d/0", beats, bad, NREGS); end
    checks++; if (snap_count !== 16'd1) begin errors++; $display("FAIL t4_snap got %0d want 1", snap_count); end
  endtask

`ifdef REGSNAP_DELTA_EN
  // T5: only changed entries stream; no change gives one entry-0 beat.
  task automatic test_delta();
    int beats;
    logic done;
    do_reset();
    set_regs(32'h1000); out_ready = 1'b1;
    pulse_trigger();
    beats = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (out_valid) begin beats++; if (out_last) done = 1'b1; end
      @(negedge clock);
    end
    checks++; if (beats != NREGS) begin errors++; $display("FAIL t5_first beats got %0d want %0d", beats, NREGS); end
    regs_in[5*XLEN +: XLEN]  = 32'h0000_DEAD;
    regs_in[17*XLEN +: XLEN] = 32'h0000_BEEF;
    pulse_trigger();
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd5 || out_data !== 32'hDEAD || out_last !== 1'b0) begin
      errors++; $display("FAIL t5_beat0 got v=%0b idx=%0d data=%h last=%0b want 1/5/dead/0", out_valid, out_idx, out_data, out_last); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd17 || out_data !== 32'hBEEF || out_last !== 1'b1) begin
      errors++; $display("FAIL t5_beat1 got v=%0b idx=%0d data=%h last=%0b want 1/17/beef/1", out_valid, out_idx, out_data, out_last); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_end1 valid got %0b want 0", out_valid); end
    pulse_trigger();
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'h1000 || out_last !== 1'b1) begin
      errors++; $display("FAIL t5_nochange got v=%0b idx=%0d data=%h last=%0b want 1/0/1000/1", out_valid, out_idx, out_data, out_last); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_end2 valid got %0b want 0", out_valid); end
    checks++; if (snap_count !== 16'd3) begin errors++; $display("FAIL t5_snap got %0d want 3", snap_count); end
  endtask
`endif

  // T6: drop counter saturates at 0xFF.
  task automatic test_drop_sat();
    do_reset();
    set_regs(32'h6000); out_ready = 1'b0;
    @(negedge clock); trigger = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (drop_count !== 8'd9) begin errors++; $display("FAIL t6_drop9 got %0d want 9", drop_count); end
    repeat (290) @(negedge clock);
    checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL t6_sat got %0d want 255", drop_count); end
    checks++; if (busy !== 1'b1 || snap_count !== 16'd1) begin errors++; $display("FAIL t6_state busy=%0b snap=%0d want 1/1", busy, snap_count); end
    trigger = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 100 && busy; c++) @(negedge clock);
    checks++; if (busy !== 1'b0 || drop_count !== 8'hFF) begin errors++; $display("FAIL t6_drain busy=%0b drop=%0d want 0/255", busy, drop_count); end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_stall();
    test_held_trigger();
    test_mid_reset();
`ifdef REGSNAP_DELTA_EN
    test_delta();
`endif
    test_drop_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
